// File: rtl/flash_cache_pkg.sv
// Shared constants for the flash read cache: FSM state encodings, bus widths
// and the address-split helper used to locate word index and tag bits.
package flash_cache_pkg;

    localparam int WORD_W        = 32;
    localparam int QSPI_AW       = 24;
    localparam int BYTE_OFS_BITS = 2;

    typedef logic [WORD_W-1:0] word_t;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_START   = 2'd1;
    localparam logic [1:0] ST_FILL    = 2'd2;
    localparam logic [1:0] ST_RESPOND = 2'd3;

    // Number of word-index bits for a line of line_words 32-bit words.
    function automatic int line_idx_bits(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int tag_bits(input int addr_width, input int line_words);
        return addr_width - line_idx_bits(line_words) - BYTE_OFS_BITS;
    endfunction

endpackage

// File: rtl/flash_cache_if.sv
// Host-side and QSPI-side signal bundle of the flash read cache.
interface flash_cache_if #(
    parameter int ADDR_WIDTH = 24
);
    import flash_cache_pkg::*;

    logic                  cache_enable;
    logic                  cache_flush;
    logic                  cache_read;
    logic [ADDR_WIDTH-1:0] cache_address;
    word_t                 cache_readData;
    logic                  cache_readReady;
    logic                  cache_busy;

    logic                  qspi_enable;
    logic [QSPI_AW-1:0]    qspi_address;
    logic                  qspi_changeAddress;
    logic                  qspi_requestData;
    word_t                 qspi_readData;
    logic                  qspi_readDataValid;
    logic                  qspi_initialised;
    logic                  qspi_busy;

    modport slave (
        input  cache_enable, cache_flush, cache_read, cache_address,
        input  qspi_readData, qspi_readDataValid, qspi_initialised, qspi_busy,
        output cache_readData, cache_readReady, cache_busy,
        output qspi_enable, qspi_address, qspi_changeAddress, qspi_requestData
    );

    modport master (
        output cache_enable, cache_flush, cache_read, cache_address,
        output qspi_readData, qspi_readDataValid, qspi_initialised, qspi_busy,
        input  cache_readData, cache_readReady, cache_busy,
        input  qspi_enable, qspi_address, qspi_changeAddress, qspi_requestData
    );

endinterface

// File: rtl/flash_cache_line_store.sv
// Single cache line: data words (not reset) plus per-word valid bits,
// one write port from the fill path and one combinational read port.
module cache_line_store
    import flash_cache_pkg::*;
#(
    parameter int LINE_WORDS = 8,
    parameter int IW         = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clear,
    input  logic          i_we,
    input  logic [IW-1:0] i_waddr,
    input  word_t         i_wdata,
    input  logic [IW-1:0] i_raddr,
    output word_t         o_rdata,
    output logic          o_rvalid
);

    word_t                 r_data [LINE_WORDS];
    logic [LINE_WORDS-1:0] r_valid;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_data[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
        end else if (i_clear) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_waddr] <= 1'b1;
        end
    end

    assign o_rdata  = r_data[i_raddr];
    assign o_rvalid = r_valid[i_raddr];

endmodule

// File: rtl/flash_cache.sv
// Single-line flash read cache with critical-word early restart.
// state   | meaning
// IDLE    | serve hits, launch a fill on a miss, apply flushes directly
// START   | pulse qspi_changeAddress once the device is not busy
// FILL    | collect LINE_WORDS words in order, serve words as they land
// RESPOND | fill done; apply any flush recorded during the fill
module flash_cache
    import flash_cache_pkg::*;
#(
    parameter int LINE_WORDS = 8,
    parameter int ADDR_WIDTH = 24
) (
    input  logic         clk,
    input  logic         rst,
    flash_cache_if.slave bus
);

    localparam int IW = line_idx_bits(LINE_WORDS);
    localparam int TW = tag_bits(ADDR_WIDTH, LINE_WORDS);

    logic [1:0]    r_state;
    logic [TW-1:0] r_tag;
    logic          r_line_valid;
    logic          r_flush_pend;
    logic          r_ready;
    word_t         r_rdata;
    logic [IW-1:0] r_fill_cnt;

    logic [IW-1:0] w_idx;
    logic [TW-1:0] w_tag;
    word_t         w_st_rdata;
    logic          w_st_rvalid;
    logic          w_req_live;
    logic          w_tag_match;
    logic          w_hit;
    logic          w_miss;
    logic          w_start;
    logic          w_chg;
    logic          w_fill_wr;
    logic          w_fill_last;
    logic          w_bypass;
    logic          w_unused_addr_lsbs;

    assign w_idx = bus.cache_address[IW+1:BYTE_OFS_BITS];
    assign w_tag = bus.cache_address[ADDR_WIDTH-1:IW+BYTE_OFS_BITS];
    assign w_unused_addr_lsbs = ^bus.cache_address[BYTE_OFS_BITS-1:0];

    // r_ready masks the request for the cycle in which the host still holds it
    assign w_req_live  = bus.cache_read && bus.cache_enable && !r_ready;
    assign w_tag_match = r_line_valid && (w_tag == r_tag);
    assign w_hit       = w_req_live && w_tag_match && w_st_rvalid;
    assign w_miss      = w_req_live && !w_hit;
    assign w_start     = (r_state == ST_IDLE) && w_miss && bus.qspi_initialised;
    assign w_chg       = (r_state == ST_START) && !bus.qspi_busy && bus.cache_enable;
    assign w_fill_wr   = (r_state == ST_FILL) && bus.qspi_readDataValid;
    assign w_fill_last = w_fill_wr && (r_fill_cnt == IW'(LINE_WORDS - 1));
    // Word arriving now is the one the host waits for: forward it directly
    assign w_bypass    = w_req_live && w_tag_match && w_fill_wr && (r_fill_cnt == w_idx);

    cache_line_store #(
        .LINE_WORDS (LINE_WORDS),
        .IW         (IW)
    ) u_store (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_start),
        .i_we     (w_fill_wr),
        .i_waddr  (r_fill_cnt),
        .i_wdata  (bus.qspi_readData),
        .i_raddr  (w_idx),
        .o_rdata  (w_st_rdata),
        .o_rvalid (w_st_rvalid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_tag        <= '0;
            r_line_valid <= 1'b0;
            r_flush_pend <= 1'b0;
            r_ready      <= 1'b0;
            r_rdata      <= '0;
            r_fill_cnt   <= '0;
        end else begin
            r_ready <= w_hit || w_bypass;
            if (w_bypass) begin
                r_rdata <= bus.qspi_readData;
            end else if (w_hit) begin
                r_rdata <= w_st_rdata;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state      <= ST_START;
                        r_tag        <= w_tag;
                        r_line_valid <= 1'b1;
                        r_fill_cnt   <= '0;
                        r_flush_pend <= 1'b0;
                    end else if (bus.cache_flush) begin
                        r_line_valid <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bus.cache_flush) r_flush_pend <= 1'b1;
                    if (w_chg) r_state <= ST_FILL;
                end
                ST_FILL: begin
                    if (bus.cache_flush) r_flush_pend <= 1'b1;
                    if (w_fill_wr) begin
                        r_fill_cnt <= r_fill_cnt + 1'b1;
                        if (w_fill_last) r_state <= ST_RESPOND;
                    end
                end
                ST_RESPOND: begin
                    r_state <= ST_IDLE;
                    if (r_flush_pend || bus.cache_flush) begin
                        r_line_valid <= 1'b0;
                        r_flush_pend <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cache_readReady    = r_ready;
    assign bus.cache_readData     = r_rdata;
    assign bus.cache_busy         = (r_state == ST_START) || (r_state == ST_FILL);
    assign bus.qspi_enable        = bus.cache_enable;
    assign bus.qspi_changeAddress = w_chg;
    assign bus.qspi_requestData   = (r_state == ST_FILL) && !w_fill_last;
    assign bus.qspi_address       = QSPI_AW'({r_tag, {(IW + BYTE_OFS_BITS){1'b0}}});

endmodule

// File: tb/tb_flash_cache.sv
// Self-checking bench for flash_cache: behavioural flash device and a
// line-level cache model; directed scenarios followed by random reads.
module tb_flash_cache;
    import flash_cache_pkg::*;

    localparam int LW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    flash_cache_if #(.ADDR_WIDTH(24)) bus ();

    flash_cache #(.LINE_WORDS(LW), .ADDR_WIDTH(24)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic        s_ready, s_busy, s_chg, s_req, s_qen;
    logic [31:0] s_data;
    logic [23:0] s_addr;
    int          s_cyc;

    bit          fl_active = 0;
    logic [23:0] fl_base;
    int          fl_cnt = 0;
    int          fl_gap = 0;
    bit          stray = 0;
    int          rdv_cyc [16];
    bit          rdv_req [16];
    int          fill_done_cyc = 0;
    int          n_chg = 0;
    int          n_req_cyc = 0;
    int          bad_chg_busy = 0;
    logic [23:0] last_chg_addr = '0;

    bit          m_valid = 0;
    logic [23:0] m_base = '0;

    function automatic logic [31:0] flash_word(input logic [23:0] a);
        logic [31:0] x;
        x = {8'h00, a[23:2], 2'b00};
        return (x * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction

    function automatic logic [23:0] line_base(input logic [23:0] a);
        return a & ~24'(LW * 4 - 1);
    endfunction

    // One clock: flash device drives, outputs sampled at negedge.
    task automatic tick();
        bus.qspi_busy = fl_active ? 1'b0 : ($urandom_range(0, 3) == 0);
        if (stray) begin
            bus.qspi_readDataValid = 1'b1;
            bus.qspi_readData      = 32'hDEAD_BEEF;
        end else if (fl_active && fl_gap == 0) begin
            bus.qspi_readDataValid = 1'b1;
            bus.qspi_readData      = flash_word(fl_base + 24'(4 * fl_cnt));
        end else begin
            bus.qspi_readDataValid = 1'b0;
            if (fl_active) fl_gap--;
        end
        @(negedge clk);
        s_ready = bus.cache_readReady;
        s_data  = bus.cache_readData;
        s_busy  = bus.cache_busy;
        s_chg   = bus.qspi_changeAddress;
        s_req   = bus.qspi_requestData;
        s_addr  = bus.qspi_address;
        s_qen   = bus.qspi_enable;
        s_cyc   = cyc;
        if (s_req) n_req_cyc++;
        if (s_chg && bus.qspi_busy) bad_chg_busy++;
        if (bus.qspi_readDataValid && !stray && fl_active) begin
            rdv_req[fl_cnt] = s_req;
            rdv_cyc[fl_cnt] = cyc;
            fl_cnt++;
            fl_gap = $urandom_range(0, 2);
            if (fl_cnt == LW) begin
                fl_active     = 0;
                fill_done_cyc = cyc;
            end
        end
        if (s_chg) begin
            n_chg++;
            last_chg_addr = s_addr;
            fl_active = 1;
            fl_base   = s_addr;
            fl_cnt    = 0;
            fl_gap    = $urandom_range(1, 3);
        end
        @(posedge clk);
        #1;
        bus.qspi_readDataValid = 1'b0;
        cyc++;
    endtask

    task automatic host_read(input logic [23:0] a, input bit flush_first,
                             output logic [31:0] d, output int lat, output bit ok);
        int t0;
        t0 = cyc;
        ok = 0;
        lat = -1;
        d = '0;
        bus.cache_address = a;
        bus.cache_read    = 1'b1;
        bus.cache_flush   = flush_first;
        for (int i = 0; i < 200; i++) begin
            tick();
            bus.cache_flush = 1'b0;
            if (s_ready) begin
                ok  = 1;
                d   = s_data;
                lat = s_cyc - t0;
                break;
            end
        end
        bus.cache_read = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (!s_busy && !fl_active) begin
                ok = 1;
                break;
            end
        end
        tick();
        tick();
    endtask

    task automatic flush_idle();
        bus.cache_flush = 1'b1;
        tick();
        bus.cache_flush = 1'b0;
        tick();
        m_valid = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.cache_enable = 1'b0;
        tick();
        n_checks++;
        if ({s_ready, s_data, s_busy, s_addr, s_chg, s_req} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%0b data=%h busy=%0b addr=%h chg=%0b req=%0b, expected all 0",
                     s_ready, s_data, s_busy, s_addr, s_chg, s_req);
        end
        n_checks++;
        if (s_qen !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_qspi_enable_low: got %0b expected 0", s_qen);
        end
        bus.cache_enable = 1'b1;
        tick();
        n_checks++;
        if (s_qen !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_qspi_enable_high: got %0b expected 1", s_qen);
        end
        rst_n = 1'b1;
        tick();
        tick();
        n_checks++;
        if (s_busy !== 1'b0 || s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got busy=%0b rdy=%0b expected 0 0", s_busy, s_ready);
        end
    endtask

    task automatic test_cold_miss();
        logic [31:0] d;
        int lat, c0;
        bit ok, ok2, all_hi;
        c0 = n_chg;
        host_read(24'h000104, 0, d, lat, ok);
        n_checks++;
        if (!ok || d !== flash_word(24'h000104)) begin
            n_fail++;
            $display("FAIL cold_miss_data: got ok=%0b data=%h expected %h", ok, d, flash_word(24'h000104));
        end
        n_checks++;
        if (s_cyc !== rdv_cyc[1] + 1) begin
            n_fail++;
            $display("FAIL cold_miss_early_restart: ready at cycle %0d expected %0d", s_cyc, rdv_cyc[1] + 1);
        end
        n_checks++;
        if (n_chg - c0 !== 1 || last_chg_addr !== 24'h000100) begin
            n_fail++;
            $display("FAIL cold_miss_change_address: got %0d pulses addr=%h expected 1 at 000100",
                     n_chg - c0, last_chg_addr);
        end
        wait_idle(ok2);
        n_checks++;
        if (!ok2 || fl_cnt !== LW) begin
            n_fail++;
            $display("FAIL cold_miss_fill_done: got ok=%0b words=%0d expected 1 %0d", ok2, fl_cnt, LW);
        end
        all_hi = 1;
        for (int i = 0; i < LW - 1; i++) all_hi &= rdv_req[i];
        n_checks++;
        if (rdv_req[LW-1] !== 1'b0 || !all_hi) begin
            n_fail++;
            $display("FAIL request_data_profile: got last=%0b earlier_all_high=%0b expected 0 1",
                     rdv_req[LW-1], all_hi);
        end
        m_valid = 1;
        m_base  = 24'h000100;
    endtask

    task automatic test_hit();
        logic [31:0] d;
        int lat, c0, q0;
        bit ok;
        c0 = n_chg;
        q0 = n_req_cyc;
        host_read(24'h00011C, 0, d, lat, ok);
        n_checks++;
        if (!ok || lat !== 1 || d !== flash_word(24'h00011C)) begin
            n_fail++;
            $display("FAIL hit_0x11C: got ok=%0b lat=%0d data=%h expected 1 1 %h", ok, lat, d, flash_word(24'h00011C));
        end
        n_checks++;
        if (n_chg !== c0 || n_req_cyc !== q0) begin
            n_fail++;
            $display("FAIL hit_no_qspi: got chg=%0d req_cycles=%0d expected 0 0", n_chg - c0, n_req_cyc - q0);
        end
    endtask

    task automatic test_held_miss();
        logic [31:0] d;
        int lat, c0;
        bit ok, busy_at_issue;
        flush_idle();
        host_read(24'h000108, 0, d, lat, ok);
        n_checks++;
        if (!ok || d !== flash_word(24'h000108) || lat <= 1) begin
            n_fail++;
            $display("FAIL refill_0x108: got ok=%0b lat=%0d data=%h expected miss with %h", ok, lat, d, flash_word(24'h000108));
        end
        busy_at_issue = s_busy;
        c0 = n_chg;
        host_read(24'h000200, 0, d, lat, ok);
        n_checks++;
        if (busy_at_issue !== 1'b1 || !ok || d !== flash_word(24'h000200)) begin
            n_fail++;
            $display("FAIL held_miss_data: got busy_at_issue=%0b ok=%0b data=%h expected 1 1 %h",
                     busy_at_issue, ok, d, flash_word(24'h000200));
        end
        n_checks++;
        if (s_cyc <= fill_done_cyc) begin
            n_fail++;
            $display("FAIL held_miss_wait: ready at cycle %0d, required after fill end %0d", s_cyc, fill_done_cyc);
        end
        n_checks++;
        if (n_chg - c0 !== 1 || last_chg_addr !== 24'h000200) begin
            n_fail++;
            $display("FAIL held_miss_change_address: got %0d pulses addr=%h expected 1 at 000200",
                     n_chg - c0, last_chg_addr);
        end
        wait_idle(ok);
        m_valid = 1;
        m_base  = 24'h000200;
    endtask

    task automatic test_flush_mid_fill();
        logic [31:0] d;
        int lat, c0;
        bit ok, busy_at_flush;
        host_read(24'h000100, 0, d, lat, ok);
        for (int i = 0; i < 100 && fl_cnt < 3; i++) tick();
        busy_at_flush = s_busy;
        bus.cache_flush = 1'b1;
        tick();
        bus.cache_flush = 1'b0;
        wait_idle(ok);
        n_checks++;
        if (busy_at_flush !== 1'b1 || !ok || fl_cnt !== LW) begin
            n_fail++;
            $display("FAIL flush_mid_fill_completes: got busy=%0b ok=%0b words=%0d expected 1 1 %0d",
                     busy_at_flush, ok, fl_cnt, LW);
        end
        c0 = n_chg;
        host_read(24'h000100, 0, d, lat, ok);
        n_checks++;
        if (!ok || n_chg - c0 !== 1 || lat <= 1 || d !== flash_word(24'h000100)) begin
            n_fail++;
            $display("FAIL flush_then_refetch: got ok=%0b chg=%0d lat=%0d data=%h expected refetch of %h",
                     ok, n_chg - c0, lat, d, flash_word(24'h000100));
        end
        wait_idle(ok);
        m_valid = 1;
        m_base  = 24'h000100;
    endtask

    task automatic test_reset_mid_fill();
        logic [31:0] d;
        int lat, c0;
        bit ok, any_act;
        flush_idle();
        host_read(24'h000100, 0, d, lat, ok);
        for (int i = 0; i < 100 && fl_cnt < 4; i++) tick();
        rst_n = 1'b0;
        fl_active = 0;
        tick();
        n_checks++;
        if ({s_ready, s_data, s_busy, s_addr, s_chg, s_req} !== '0 || s_qen !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_fill_outputs: got rdy=%0b data=%h busy=%0b addr=%h chg=%0b req=%0b qen=%0b, expected zeros qen=1",
                     s_ready, s_data, s_busy, s_addr, s_chg, s_req, s_qen);
        end
        bus.cache_enable = 1'b0;
        tick();
        n_checks++;
        if (s_qen !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_fill_qspi_enable: got %0b expected 0", s_qen);
        end
        bus.cache_enable = 1'b1;
        rst_n = 1'b1;
        tick();
        any_act = 0;
        stray = 1;
        tick();
        stray = 0;
        any_act |= s_ready | s_busy;
        tick();
        any_act |= s_ready | s_busy;
        n_checks++;
        if (any_act !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_valid_ignored: got activity=%0b expected 0", any_act);
        end
        m_valid = 0;
        c0 = n_chg;
        host_read(24'h000100, 0, d, lat, ok);
        n_checks++;
        if (!ok || n_chg - c0 !== 1 || d !== flash_word(24'h000100)) begin
            n_fail++;
            $display("FAIL post_reset_miss: got ok=%0b chg=%0d data=%h expected 1 1 %h",
                     ok, n_chg - c0, d, flash_word(24'h000100));
        end
        wait_idle(ok);
        m_valid = 1;
        m_base  = 24'h000100;
    endtask

    task automatic test_init_low();
        logic [31:0] d;
        int lat, c0;
        bit ok, any_act;
        c0 = n_chg;
        any_act = 0;
        bus.qspi_initialised = 1'b0;
        bus.cache_address    = 24'h000300;
        bus.cache_read       = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            any_act |= s_ready | s_chg;
        end
        n_checks++;
        if (any_act !== 1'b0) begin
            n_fail++;
            $display("FAIL init_low_hold: got activity=%0b expected 0", any_act);
        end
        bus.qspi_initialised = 1'b1;
        host_read(24'h000300, 0, d, lat, ok);
        n_checks++;
        if (!ok || n_chg - c0 !== 1 || last_chg_addr !== 24'h000300 || d !== flash_word(24'h000300)) begin
            n_fail++;
            $display("FAIL init_rise_fill: got ok=%0b chg=%0d addr=%h data=%h expected 1 1 000300 %h",
                     ok, n_chg - c0, last_chg_addr, d, flash_word(24'h000300));
        end
        wait_idle(ok);
        m_valid = 1;
        m_base  = 24'h000300;
    endtask

    task automatic test_enable_low();
        logic [31:0] d;
        int lat, c0;
        bit ok, any_act, qen_seen;
        c0 = n_chg;
        any_act = 0;
        qen_seen = 0;
        bus.cache_enable  = 1'b0;
        bus.cache_address = 24'h00030C;
        bus.cache_read    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            any_act  |= s_ready | s_chg;
            qen_seen |= s_qen;
        end
        n_checks++;
        if (any_act !== 1'b0 || qen_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_low_hold: got activity=%0b qspi_enable_seen=%0b expected 0 0", any_act, qen_seen);
        end
        bus.cache_enable = 1'b1;
        host_read(24'h00030C, 0, d, lat, ok);
        n_checks++;
        if (!ok || lat !== 1 || n_chg !== c0 || d !== flash_word(24'h00030C)) begin
            n_fail++;
            $display("FAIL enable_rise_hit: got ok=%0b lat=%0d chg=%0d data=%h expected 1 1 0 %h",
                     ok, lat, n_chg - c0, d, flash_word(24'h00030C));
        end
    endtask

    task automatic test_flush_hit();
        logic [31:0] d;
        int lat, c0;
        bit ok;
        host_read(24'h000304, 1, d, lat, ok);
        n_checks++;
        if (!ok || lat !== 1 || d !== flash_word(24'h000304)) begin
            n_fail++;
            $display("FAIL flush_with_hit_served: got ok=%0b lat=%0d data=%h expected 1 1 %h",
                     ok, lat, d, flash_word(24'h000304));
        end
        tick();
        c0 = n_chg;
        host_read(24'h000308, 0, d, lat, ok);
        n_checks++;
        if (!ok || n_chg - c0 !== 1 || d !== flash_word(24'h000308)) begin
            n_fail++;
            $display("FAIL flush_with_hit_invalidates: got ok=%0b chg=%0d data=%h expected 1 1 %h",
                     ok, n_chg - c0, d, flash_word(24'h000308));
        end
        wait_idle(ok);
        m_valid = 1;
        m_base  = 24'h000300;
    endtask

    task automatic test_random();
        logic [23:0] bases [4];
        logic [23:0] a;
        logic [31:0] d;
        int lat, c0;
        bit ok, exp_hit;
        bases[0] = 24'h000000;
        bases[1] = 24'h000100;
        bases[2] = 24'h7FFFE0;
        bases[3] = 24'hABCDE0;
        flush_idle();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                flush_idle();
                continue;
            end
            a = bases[$urandom_range(0, 3)] | 24'($urandom_range(0, LW * 4 - 1));
            exp_hit = m_valid && (m_base == line_base(a));
            c0 = n_chg;
            host_read(a, 0, d, lat, ok);
            n_checks++;
            if (!ok || d !== flash_word(a)) begin
                n_fail++;
                $display("FAIL rand_data a=%h: got ok=%0b data=%h expected %h", a, ok, d, flash_word(a));
            end
            if (exp_hit) begin
                n_checks++;
                if (lat !== 1 || n_chg !== c0) begin
                    n_fail++;
                    $display("FAIL rand_hit a=%h: got lat=%0d chg=%0d expected 1 0", a, lat, n_chg - c0);
                end
            end else begin
                n_checks++;
                if (n_chg - c0 !== 1 || last_chg_addr !== line_base(a) || lat <= 1) begin
                    n_fail++;
                    $display("FAIL rand_miss a=%h: got chg=%0d addr=%h lat=%0d expected 1 %h >1",
                             a, n_chg - c0, last_chg_addr, lat, line_base(a));
                end
                wait_idle(ok);
                n_checks++;
                if (!ok) begin
                    n_fail++;
                    $display("FAIL rand_fill_timeout a=%h: got busy=%0b expected idle", a, s_busy);
                end
            end
            m_valid = 1;
            m_base  = line_base(a);
        end
        n_checks++;
        if (bad_chg_busy !== 0) begin
            n_fail++;
            $display("FAIL change_address_while_busy: got %0d pulses expected 0", bad_chg_busy);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cache_enable       = 1'b0;
        bus.cache_flush        = 1'b0;
        bus.cache_read         = 1'b0;
        bus.cache_address      = '0;
        bus.qspi_readData      = '0;
        bus.qspi_readDataValid = 1'b0;
        bus.qspi_initialised   = 1'b1;
        bus.qspi_busy          = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_cold_miss();
        test_hit();
        test_held_miss();
        test_flush_mid_fill();
        test_reset_mid_fill();
        test_init_low();
        test_enable_low();
        test_flush_hit();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/flash_cache.md
FLASH_CACHE -- requirements
Module: flash_cache

Interface
REQ-001 Parameter LINE_WORDS, default 8, number of 32-bit words per cache line; legal values are 2, 4, 8 and 16.
REQ-002 Parameter ADDR_WIDTH, default 24, flash byte-address width.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 cache_enable  input  1  enables the block; when low, no new flash traffic is started.
REQ-007 cache_flush  input  1  one-cycle pulse that invalidates the line.
REQ-008 cache_read  input  1  level read request from the host, held until cache_readReady.
REQ-009 cache_address  input  ADDR_WIDTH  host byte address; bits [1:0] are ignored.
REQ-010 cache_readData  output  32  returned word, valid while cache_readReady is high.
REQ-011 cache_readReady  output  1  one-cycle completion pulse.
REQ-012 cache_busy  output  1  high while a line fill is in progress.
REQ-013 qspi_enable  output  1  equals cache_enable.
REQ-014 qspi_address  output  24  line base address {tag, zeros}.
REQ-015 qspi_changeAddress  output  1  one-cycle pulse that starts a line fill.
REQ-016 qspi_requestData  output  1  level signal requesting further sequential words.
REQ-017 qspi_readData  input  32  word from the flash device, already byte-ordered.
REQ-018 qspi_readDataValid  input  1  one-cycle pulse; qspi_readData is valid.
REQ-019 qspi_initialised  input  1  the flash device has completed its wake sequence.
REQ-020 qspi_busy  input  1  the flash device is mid-transaction.

Function
REQ-021 Address split: word index = addr[log2(LINE_WORDS)+1:2]; tag = addr[ADDR_WIDTH-1:log2(LINE_WORDS)+2].
REQ-022 Storage: one line consisting of LINE_WORDS x 32-bit data words, one tag register, one line-valid bit and LINE_WORDS per-word valid bits.
REQ-023 Hit: cache_read high, line-valid set, tag equal and the indexed word-valid bit set.
REQ-024 On a hit, cache_readReady SHALL pulse high on the next cycle, with cache_readData holding the indexed word.
REQ-025 The FSM SHALL have the states IDLE, START, FILL and RESPOND.
REQ-026 IDLE -> START: on a miss, when cache_enable and qspi_initialised are both high; the tag is latched, all word-valid bits are cleared and line-valid is set.
REQ-027 START: qspi_changeAddress SHALL pulse for exactly one cycle, only in a cycle where qspi_busy is low; the FSM then moves to FILL.
REQ-028 FILL: qspi_requestData SHALL be high except in the cycle in which qspi_readDataValid arrives with fill count = LINE_WORDS-1, when it SHALL be low.
REQ-029 FILL: each qspi_readDataValid pulse SHALL write word[fill count], set its word-valid bit and increment the fill count; the fill count starts at 0 and follows the word index order.
REQ-030 Early restart: in FILL, a pending host read whose word becomes valid SHALL receive cache_readReady on the next cycle, without waiting for the fill to end.
REQ-031 FILL -> RESPOND after the last word is written; RESPOND -> IDLE after one cycle, in which any pending flush or miss is evaluated.
REQ-032 A host request to a different line during FILL SHALL be held (no readReady) until the fill completes, then SHALL be treated as a new miss.
REQ-033 cache_flush in IDLE SHALL clear line-valid on the next cycle.
REQ-034 cache_flush during START or FILL SHALL be recorded and applied on the RESPOND -> IDLE transition; the fill itself SHALL NOT be aborted.
REQ-035 A simultaneous flush and hit in IDLE: the hit SHALL be served and the line then invalidated.
REQ-036 cache_enable low with cache_read high: no readReady and no changeAddress until cache_enable returns high.
REQ-037 cache_busy SHALL be high exactly in the START and FILL states.

Reset
REQ-038 While rst is low: FSM = IDLE; line-valid, word-valid bits, fill count and pending flush all cleared.
REQ-039 While rst is low, all outputs SHALL be 0 except qspi_enable, which follows cache_enable.
REQ-040 Reset asserted mid-fill SHALL abandon the fill; any qspi_readDataValid pulse arriving after reset is released and outside FILL SHALL be ignored.
REQ-041 The data word array is not reset.

Structure
REQ-042 The FSM state encodings and the address-split width constants SHALL live in the shared flash package.
REQ-043 A single sub-module, cache_line_store, SHALL hold the data words and valid bits, with one write port and one read port.

Verification
REQ-044 Cold miss at 0x000104 -> one changeAddress pulse with qspi_address=0x000100; the word at 0x104 is returned right after the 2nd readDataValid; requestData is low on the 8th readDataValid.
REQ-045 Hit at 0x00011C after that fill -> readReady exactly 1 cycle later, with no qspi activity.
REQ-046 Read of 0x000200 issued during the fill of 0x000100 -> no readReady until the fill completes, then a new changeAddress with qspi_address=0x000200.
REQ-047 Flush pulse at the 3rd word of a fill -> the fill completes; a subsequent read of 0x000100 misses and refetches.
REQ-048 Reset asserted at the 4th word of a fill -> all outputs 0 (qspi_enable follows cache_enable); a stray readDataValid afterwards is ignored; the next read misses.
REQ-049 qspi_initialised low with cache_read high -> no changeAddress until qspi_initialised rises, then exactly one changeAddress pulse.
